// File: rtl/game_flow_controller_if.sv
// Handshake bundle between the game flow controller, the ship placement
// block and the board lookup that resolves shots.
interface game_flow_controller_if;
    logic       place_done;
    logic       place_error;
    logic       placement_en;
    logic [2:0] ships_to_place;
    logic       shot_req;
    logic       shot_is_pc;
    logic       shot_ack;
    logic       shot_hit;

    modport master (
        output placement_en, ships_to_place, shot_req, shot_is_pc,
        input  place_done, place_error, shot_ack, shot_hit
    );

    modport slave (
        input  placement_en, ships_to_place, shot_req, shot_is_pc,
        output place_done, place_error, shot_ack, shot_hit
    );
endinterface

// File: rtl/game_flow_controller.sv
// Battleship game sequencer: placement, alternating player/PC turns with a
// per-turn countdown, hit bookkeeping and win/lose detection.
module game_flow_controller #(
    parameter int N_SHIPS   = 3,
    parameter int TURN_TIME = 10
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start_btn,
    input  logic                          fire_btn,
    input  logic                          sec_tick,
    game_flow_controller_if.master        bus,
    output logic [2:0]                    state,
    output logic [3:0]                    timer,
    output logic [4:0]                    player_hits,
    output logic [4:0]                    pc_hits,
    output logic                          win,
    output logic                          lose
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_PLACE   = 3'd1;
    localparam logic [2:0] S_P_TURN  = 3'd2;
    localparam logic [2:0] S_P_WAIT  = 3'd3;
    localparam logic [2:0] S_PC_TURN = 3'd4;
    localparam logic [2:0] S_PC_WAIT = 3'd5;
    localparam logic [2:0] S_OVER    = 3'd6;

    localparam int         TOTAL_I    = N_SHIPS * (N_SHIPS + 1) / 2;
    localparam logic [4:0] TOTAL      = 5'(TOTAL_I);
    localparam logic [2:0] SHIPS_INIT = 3'(N_SHIPS);
    localparam logic [3:0] TURN_INIT  = 4'(TURN_TIME);

    logic [2:0] state_q, state_d;
    logic [2:0] ships_q, ships_d;
    logic [3:0] timer_q, timer_d;
    logic [4:0] player_hits_q, player_hits_d;
    logic [4:0] pc_hits_q, pc_hits_d;
    logic       placement_en_q, placement_en_d;
    logic       shot_req_q, shot_req_d;
    logic       shot_is_pc_q, shot_is_pc_d;
    logic       win_q, win_d;
    logic       lose_q, lose_d;
    logic       start_prev_q, start_prev_d;
    logic       fire_prev_q, fire_prev_d;
    logic       start_press;
    logic       fire_press;

    // Buttons are active-low: a press is the falling edge against last cycle.
    assign start_press  = start_prev_q & ~start_btn;
    assign fire_press   = fire_prev_q & ~fire_btn;
    assign start_prev_d = start_btn;
    assign fire_prev_d  = fire_btn;

    always_comb begin
        state_d       = state_q;
        ships_d       = ships_q;
        timer_d       = timer_q;
        player_hits_d = player_hits_q;
        pc_hits_d     = pc_hits_q;
        shot_req_d    = shot_req_q;
        shot_is_pc_d  = shot_is_pc_q;

        case (state_q)
            S_IDLE, S_OVER: begin
                if (start_press) begin
                    state_d       = S_PLACE;
                    ships_d       = SHIPS_INIT;
                    timer_d       = 4'd0;
                    player_hits_d = 5'd0;
                    pc_hits_d     = 5'd0;
                    shot_req_d    = 1'b0;
                end
            end
            S_PLACE: begin
                if (ships_q == 3'd0) begin
                    state_d = S_P_TURN;
                    timer_d = TURN_INIT;
                end else if (bus.place_done) begin
                    ships_d = ships_q - 3'd1;
                end
            end
            S_P_TURN: begin
                // Fire takes priority over a coincident timeout.
                if (fire_press) begin
                    state_d      = S_P_WAIT;
                    shot_req_d   = 1'b1;
                    shot_is_pc_d = 1'b0;
                end else if (sec_tick) begin
                    if (timer_q <= 4'd1) begin
                        timer_d = 4'd0;
                        state_d = S_PC_TURN;
                    end else begin
                        timer_d = timer_q - 4'd1;
                    end
                end
            end
            S_P_WAIT: begin
                if (bus.shot_ack) begin
                    shot_req_d = 1'b0;
                    if (bus.shot_hit && (player_hits_q < TOTAL))
                        player_hits_d = player_hits_q + 5'd1;
                    state_d = (player_hits_d == TOTAL) ? S_OVER : S_PC_TURN;
                end
            end
            S_PC_TURN: begin
                state_d      = S_PC_WAIT;
                shot_req_d   = 1'b1;
                shot_is_pc_d = 1'b1;
            end
            S_PC_WAIT: begin
                if (bus.shot_ack) begin
                    shot_req_d = 1'b0;
                    if (bus.shot_hit && (pc_hits_q < TOTAL))
                        pc_hits_d = pc_hits_q + 5'd1;
                    if (pc_hits_d == TOTAL) begin
                        state_d = S_OVER;
                    end else begin
                        state_d = S_P_TURN;
                        timer_d = TURN_INIT;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        placement_en_d = (state_d == S_PLACE);
        win_d          = (state_d == S_OVER) && (player_hits_d == TOTAL);
        lose_d         = (state_d == S_OVER) && (pc_hits_d == TOTAL);
    end

    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= S_IDLE;
            ships_q        <= 3'd0;
            timer_q        <= 4'd0;
            player_hits_q  <= 5'd0;
            pc_hits_q      <= 5'd0;
            placement_en_q <= 1'b0;
            shot_req_q     <= 1'b0;
            shot_is_pc_q   <= 1'b0;
            win_q          <= 1'b0;
            lose_q         <= 1'b0;
            start_prev_q   <= 1'b1;
            fire_prev_q    <= 1'b1;
        end else begin
            state_q        <= state_d;
            ships_q        <= ships_d;
            timer_q        <= timer_d;
            player_hits_q  <= player_hits_d;
            pc_hits_q      <= pc_hits_d;
            placement_en_q <= placement_en_d;
            shot_req_q     <= shot_req_d;
            shot_is_pc_q   <= shot_is_pc_d;
            win_q          <= win_d;
            lose_q         <= lose_d;
            start_prev_q   <= start_prev_d;
            fire_prev_q    <= fire_prev_d;
        end
    end

    assign state              = state_q;
    assign timer              = timer_q;
    assign player_hits        = player_hits_q;
    assign pc_hits            = pc_hits_q;
    assign win                = win_q;
    assign lose               = lose_q;
    assign bus.placement_en   = placement_en_q;
    assign bus.ships_to_place = ships_q;
    assign bus.shot_req       = shot_req_q;
    assign bus.shot_is_pc     = shot_is_pc_q;

endmodule

// File: tb/tb_game_flow_controller.sv
// Scoreboard bench: stimulus queues expected output snapshots, a monitor pops
// one on every output change (or at a hold probe) and compares.
module tb_game_flow_controller;

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] PLACE   = 3'd1;
    localparam logic [2:0] P_TURN  = 3'd2;
    localparam logic [2:0] P_WAIT  = 3'd3;
    localparam logic [2:0] PC_TURN = 3'd4;
    localparam logic [2:0] PC_WAIT = 3'd5;
    localparam logic [2:0] OVER    = 3'd6;

    typedef struct packed {
        logic [2:0] st;
        logic       pe;
        logic [2:0] ships;
        logic       req;
        logic       is_pc;
        logic [3:0] tmr;
        logic [4:0] ph;
        logic [4:0] pch;
        logic       win;
        logic       lose;
    } snap_t;

    typedef struct {
        string name;
        snap_t s;
    } item_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_btn;
    logic       fire_btn;
    logic       sec_tick;
    logic [2:0] state;
    logic [3:0] timer;
    logic [4:0] player_hits;
    logic [4:0] pc_hits;
    logic       win;
    logic       lose;

    logic       mon_en;
    logic       done;
    snap_t      e;
    snap_t      mon_last;
    item_t      exp_q[$];
    item_t      hold_q[$];
    int         n_run;
    int         n_fail;

    game_flow_controller_if gif ();

    game_flow_controller #(.N_SHIPS(3), .TURN_TIME(10)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_btn   (start_btn),
        .fire_btn    (fire_btn),
        .sec_tick    (sec_tick),
        .bus         (gif),
        .state       (state),
        .timer       (timer),
        .player_hits (player_hits),
        .pc_hits     (pc_hits),
        .win         (win),
        .lose        (lose)
    );

    always #5 clk = ~clk;

    function automatic snap_t snap();
        snap_t s;
        s.st    = state;
        s.pe    = gif.placement_en;
        s.ships = gif.ships_to_place;
        s.req   = gif.shot_req;
        s.is_pc = gif.shot_is_pc;
        s.tmr   = timer;
        s.ph    = player_hits;
        s.pch   = pc_hits;
        s.win   = win;
        s.lose  = lose;
        return s;
    endfunction

    function automatic string fmt(snap_t s);
        return $sformatf("st=%0d pe=%0d ships=%0d req=%0d pc=%0d tmr=%0d ph=%0d pch=%0d win=%0d lose=%0d",
                         s.st, s.pe, s.ships, s.req, s.is_pc, s.tmr, s.ph, s.pch, s.win, s.lose);
    endfunction

    // ---------------- monitor / scoreboard ----------------
    task automatic compare(item_t it, snap_t cur);
        n_run++;
        if (cur !== it.s) begin
            n_fail++;
            $display("[TB] FAIL %s: got %s, required %s", it.name, fmt(cur), fmt(it.s));
        end else begin
            $display("[TB] ok   %-22s %s", it.name, fmt(cur));
        end
    endtask

    initial begin : monitor
        snap_t cur;
        item_t it;
        logic  rst_last;
        n_run    = 0;
        n_fail   = 0;
        rst_last = 1'b1;
        mon_last = '0;
        forever begin
            @(posedge clk or negedge rst or posedge done);
            if (done === 1'b1) begin
                n_run++;
                if (exp_q.size() != 0 || hold_q.size() != 0) begin
                    n_fail++;
                    $display("[TB] FAIL queues_drained: got %0d change / %0d hold pending, required 0",
                             exp_q.size(), hold_q.size());
                end
                $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
                $finish;
            end
            #1;
            cur = snap();
            if (mon_en && !rst && rst_last) begin
                // Reset edge: outputs must already be at reset values.
                if (exp_q.size() == 0) begin
                    n_run++; n_fail++;
                    $display("[TB] FAIL unexpected_reset: got %s, required nothing queued", fmt(cur));
                end else begin
                    it = exp_q.pop_front();
                    compare(it, cur);
                end
            end else if (mon_en && cur !== mon_last) begin
                if (exp_q.size() == 0) begin
                    n_run++; n_fail++;
                    $display("[TB] FAIL unexpected_change: got %s, required %s", fmt(cur), fmt(mon_last));
                end else begin
                    it = exp_q.pop_front();
                    compare(it, cur);
                end
            end
            if (mon_en && rst && hold_q.size() > 0) begin
                it = hold_q.pop_front();
                compare(it, cur);
            end
            mon_last = cur;
            rst_last = rst;
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic expect_chg(string n);
        item_t it;
        it.name = n;
        it.s    = e;
        exp_q.push_back(it);
    endtask

    task automatic expect_hold(string n);
        item_t it;
        it.name = n;
        it.s    = e;
        hold_q.push_back(it);
    endtask

    task automatic press_start();
        start_btn = 1'b0; step(); start_btn = 1'b1; step();
    endtask

    task automatic press_fire();
        fire_btn = 1'b0; step(); fire_btn = 1'b1; step();
    endtask

    task automatic do_ack(input logic hit);
        gif.shot_ack = 1'b1; gif.shot_hit = hit; step();
        gif.shot_ack = 1'b0; gif.shot_hit = 1'b0; step();
    endtask

    task automatic place_all(input bit with_err);
        for (int s = 2; s >= 0; s--) begin
            gif.place_done = 1'b1;
            e.ships = 3'(s);
            expect_chg($sformatf("place_ships_%0d", s));
            if (s == 0) begin
                e.st = P_TURN; e.pe = 1'b0; e.tmr = 4'd10;
                expect_chg("enter_p_turn");
            end
            step(); gif.place_done = 1'b0; step();
            if (with_err && s == 2) begin
                gif.place_error = 1'b1;
                expect_hold("place_err_ignored");
                step(); gif.place_error = 1'b0; step();
            end
        end
    endtask

    task automatic timeout_run();
        for (int i = 1; i <= 10; i++) begin
            sec_tick = 1'b1;
            e.tmr = 4'(10 - i);
            if (i == 10) e.st = PC_TURN;
            expect_chg($sformatf("tick_timer_%0d", 10 - i));
            if (i == 10) begin
                e.st = PC_WAIT; e.req = 1'b1; e.is_pc = 1'b1;
                expect_chg("pc_wait_req");
            end
            step(); sec_tick = 1'b0; step();
        end
    endtask

    initial begin : stimulus
        rst = 1'b1; start_btn = 1'b1; fire_btn = 1'b1; sec_tick = 1'b0;
        gif.place_done = 1'b0; gif.place_error = 1'b0;
        gif.shot_ack = 1'b0; gif.shot_hit = 1'b0;
        mon_en = 1'b0; done = 1'b0; e = '0;
        #1 rst = 1'b0;
        repeat (3) step();
        rst = 1'b1; mon_en = 1'b1;
        expect_hold("reset_state");
        step(); step();

        // Start (held two cycles: a single press) and placement with one rejection.
        e.st = PLACE; e.pe = 1'b1; e.ships = 3'd3;
        expect_chg("start_to_place");
        start_btn = 1'b0; step(); step(); start_btn = 1'b1; step();
        place_all(1'b1);

        // Inputs that must be ignored in P_TURN.
        expect_hold("ack_ignored_p_turn");
        do_ack(1'b1);
        gif.place_done = 1'b1; expect_hold("place_ignored_p_turn");
        step(); gif.place_done = 1'b0; step();

        timeout_run();
        expect_hold("fire_ignored_pc_wait");
        press_fire();
        e.req = 1'b0; e.st = P_TURN; e.tmr = 4'd10;
        expect_chg("pc_miss_to_p_turn");
        do_ack(1'b0);

        // Fire and timeout in the same cycle.
        for (int i = 1; i <= 9; i++) begin
            sec_tick = 1'b1; e.tmr = 4'(10 - i);
            expect_chg($sformatf("tick_timer_%0d", 10 - i));
            step(); sec_tick = 1'b0; step();
        end
        e.st = P_WAIT; e.req = 1'b1; e.is_pc = 1'b0;
        expect_chg("race_fire_wins");
        fire_btn = 1'b0; sec_tick = 1'b1; step();
        fire_btn = 1'b1; sec_tick = 1'b0; step();
        sec_tick = 1'b1; expect_hold("timer_frozen_p_wait");
        step(); sec_tick = 1'b0; step();

        e.ph = 5'd1; e.req = 1'b0; e.st = PC_TURN; expect_chg("p_hit_1");
        e.st = PC_WAIT; e.req = 1'b1; e.is_pc = 1'b1; expect_chg("pc_wait_req");
        do_ack(1'b1);
        e.st = P_TURN; e.req = 1'b0; e.tmr = 4'd10; expect_chg("pc_miss_to_p_turn");
        do_ack(1'b0);

        // Fire held across a whole round: only one shot.
        e.st = P_WAIT; e.req = 1'b1; e.is_pc = 1'b0; expect_chg("held_fire_shot");
        fire_btn = 1'b0; step(); step();
        e.ph = 5'd2; e.req = 1'b0; e.st = PC_TURN; expect_chg("p_hit_2");
        e.st = PC_WAIT; e.req = 1'b1; e.is_pc = 1'b1; expect_chg("pc_wait_req");
        do_ack(1'b1);
        e.st = P_TURN; e.req = 1'b0; e.tmr = 4'd10; expect_chg("pc_miss_to_p_turn");
        do_ack(1'b0);
        expect_hold("held_fire_no_refire");
        repeat (42) step();
        fire_btn = 1'b1; step();

        // Remaining player hits up to the win.
        for (int h = 3; h <= 6; h++) begin
            e.st = P_WAIT; e.req = 1'b1; e.is_pc = 1'b0;
            expect_chg("player_fire");
            press_fire();
            e.ph = 5'(h); e.req = 1'b0;
            if (h == 6) begin
                e.st = OVER; e.win = 1'b1; expect_chg("player_wins");
                do_ack(1'b1);
            end else begin
                e.st = PC_TURN; expect_chg($sformatf("p_hit_%0d", h));
                e.st = PC_WAIT; e.req = 1'b1; e.is_pc = 1'b1; expect_chg("pc_wait_req");
                do_ack(1'b1);
                e.st = P_TURN; e.req = 1'b0; e.tmr = 4'd10; expect_chg("pc_miss_to_p_turn");
                do_ack(1'b0);
            end
        end
        expect_hold("ack_ignored_over");
        do_ack(1'b1);

        e.st = PLACE; e.pe = 1'b1; e.ships = 3'd3; e.tmr = 4'd0;
        e.ph = 5'd0; e.pch = 5'd0; e.win = 1'b0; e.lose = 1'b0;
        expect_chg("restart_clears");
        press_start();
        place_all(1'b0);

        // PC hits every shot while the player always times out.
        for (int k = 1; k <= 6; k++) begin
            timeout_run();
            e.pch = 5'(k); e.req = 1'b0;
            if (k == 6) begin
                e.st = OVER; e.lose = 1'b1; expect_chg("pc_wins");
            end else begin
                e.st = P_TURN; e.tmr = 4'd10; expect_chg($sformatf("pc_hit_%0d", k));
            end
            do_ack(1'b1);
        end

        e.st = PLACE; e.pe = 1'b1; e.ships = 3'd3; e.tmr = 4'd0;
        e.pch = 5'd0; e.lose = 1'b0;
        expect_chg("restart_after_lose");
        press_start();
        place_all(1'b0);
        timeout_run();

        // Asynchronous reset in PC_WAIT, then a stale ack.
        e = '0;
        expect_chg("reset_async");
        rst = 1'b0;
        step(); step();
        rst = 1'b1; step();
        expect_hold("stale_ack_ignored");
        do_ack(1'b1);
        step(); step();
        done = 1'b1;
    end

endmodule

// File: doc/game_flow_controller.md
GAME_FLOW_CONTROLLER -- requirements
Module: game_flow_controller

Interface
REQ-001 Parameter N_SHIPS, default 3, number of ships; ship lengths are N_SHIPS down to 1 (valid range 1..5).
REQ-002 Parameter TURN_TIME, default 10, player turn length in sec_tick pulses (valid range 1..15).
REQ-003 Port clk  in  1  single clock; all state updates on negedge clk.
REQ-004 Port rst  in  1  asynchronous, active-low reset.
REQ-005 Port start_btn  in  1  active-low pushbutton that starts a game.
REQ-006 Port fire_btn  in  1  active-low pushbutton for a player shot.
REQ-007 Port place_done  in  1  one-cycle pulse from the placement block when a ship is committed.
REQ-008 Port place_error  in  1  one-cycle pulse from the placement block when a placement is rejected.
REQ-009 Port sec_tick  in  1  one-cycle pulse, once per second.
REQ-010 Port shot_ack  in  1  one-cycle pulse from the board lookup when a shot is resolved.
REQ-011 Port shot_hit  in  1  shot result, valid only with shot_ack.
REQ-012 Port state  out  3  current FSM state encoding.
REQ-013 Port placement_en  out  1  enables the placement block.
REQ-014 Port ships_to_place  out  3  length of the ship currently being placed; 0 when none remain.
REQ-015 Port shot_req  out  1  shot request level.
REQ-016 Port shot_is_pc  out  1  1 = PC shot on the player board; 0 = player shot on the PC board.
REQ-017 Port timer  out  4  remaining player-turn seconds.
REQ-018 Port player_hits, pc_hits  out  5 each  accumulated hit counts.
REQ-019 Port win, lose  out  1 each  game-result flags.

Function
REQ-020 The FSM SHALL have states IDLE=0, PLACE=1, P_TURN=2, P_WAIT=3, PC_TURN=4, PC_WAIT=5, OVER=6.
REQ-021 A button press SHALL be a 1->0 transition of the button value registered on the previous cycle; a held button SHALL produce exactly one press.
REQ-022 IDLE: on a start_btn press, the block SHALL go to PLACE, load ships_to_place=N_SHIPS, and clear the hit counters, win, lose and timer.
REQ-023 PLACE: placement_en SHALL be 1.
REQ-024 PLACE: each place_done pulse SHALL decrement ships_to_place.
REQ-025 PLACE: place_error SHALL leave ships_to_place unchanged.
REQ-026 PLACE: the cycle after ships_to_place reaches 0, the block SHALL go to P_TURN.
REQ-027 Entering P_TURN SHALL load timer=TURN_TIME.
REQ-028 In P_TURN, each sec_tick SHALL decrement timer.
REQ-029 In P_TURN, a sec_tick with timer==1 SHALL set timer=0 and go to PC_TURN (turn forfeited, no shot).
REQ-030 In P_TURN, a fire_btn press SHALL go to P_WAIT with shot_req=1 and shot_is_pc=0.
REQ-031 A fire_btn press and a timeout in the same cycle SHALL resolve to the fire.
REQ-032 In P_WAIT, timer SHALL freeze.
REQ-033 shot_req SHALL stay high until shot_ack is seen and SHALL drop on the edge that samples shot_ack.
REQ-034 In P_WAIT on shot_ack: if shot_hit, player_hits SHALL increment.
REQ-035 In P_WAIT on shot_ack: the next state SHALL be OVER if the new player_hits equals TOTAL = N_SHIPS*(N_SHIPS+1)/2, otherwise PC_TURN.
REQ-036 PC_TURN SHALL last one cycle and then go to PC_WAIT with shot_req=1 and shot_is_pc=1.
REQ-037 In PC_WAIT on shot_ack: if shot_hit, pc_hits SHALL increment.
REQ-038 In PC_WAIT on shot_ack: the next state SHALL be OVER if the new pc_hits equals TOTAL, otherwise P_TURN.
REQ-039 In OVER, win SHALL be 1 when player_hits==TOTAL and lose SHALL be 1 when pc_hits==TOTAL.
REQ-040 OVER SHALL be held until a start_btn press, which restarts the game as in REQ-022.
REQ-041 shot_ack SHALL be ignored outside P_WAIT and PC_WAIT.
REQ-042 place_done and place_error SHALL be ignored outside PLACE.
REQ-043 fire_btn SHALL be ignored outside P_TURN.
REQ-044 Hit counters SHALL saturate at TOTAL.
REQ-045 placement_en SHALL be 0 in every state except PLACE.
REQ-046 All outputs SHALL be registered.

Reset
REQ-047 rst low SHALL immediately force, without waiting for a clock edge: state=IDLE, placement_en=0, ships_to_place=0, shot_req=0, shot_is_pc=0, timer=0, player_hits=0, pc_hits=0, win=0, lose=0, and the button history registers to 1.
REQ-048 Reset asserted mid-game (including during P_WAIT or PC_WAIT with shot_req high) SHALL abandon the shot; a later shot_ack SHALL be ignored.

Verification
REQ-049 Placement sequence: N_SHIPS=3; start press, then place_done x3 with one place_error between them -> ships_to_place steps 3,2,2,1,0, then state=P_TURN and timer=10.
REQ-050 Timeout: in P_TURN, apply 10 sec_tick pulses with no fire -> timer reaches 0, state=PC_TURN and then PC_WAIT, shot_req=1, shot_is_pc=1.
REQ-051 Fire/timeout race: fire press in the same cycle as the sec_tick with timer==1 -> state=P_WAIT, shot_is_pc=0, timer frozen at 1.
REQ-052 Player win: 6 player shot_ack pulses with shot_hit=1 (PC always misses) -> player_hits=6, state=OVER, win=1, lose=0; a later start press -> PLACE with counters cleared.
REQ-053 Held button: fire_btn held low for 50 cycles in P_TURN -> exactly one shot_req assertion.
REQ-054 Reset during wait: rst low while in PC_WAIT -> all outputs at reset values at once; shot_ack pulse after rst release -> no counter change, state=IDLE.
